// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer. On a fetch request it issues one read to the
// instruction memory at the current program counter, waits for the
// acknowledge, and then loads the returned word into the instruction register
// and advances the program counter. A taken branch can redirect the program
// counter while idle, or be held pending while a fetch is in flight.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a fetch that waits TMO_CYC cycles in WAIT without an
//   acknowledge is abandoned and the sticky fetch_err flag is set. When
//   undefined, WAIT has no limit and fetch_err is constant 0.
//
// Parameters:
//   PC_W     program counter / instruction address width
//   TMO_CYC  WAIT-cycle limit (used only with FETCH_TIMEOUT_EN)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_f       in   synchronous active-low reset
//   fetch_req   in   one-cycle request to fetch the instruction at pc
//   br_load     in   load pc from br_addr (taken branch)
//   br_addr     in   branch target
//   imem_req    out  instruction memory read request
//   imem_addr   out  read address (pc, stable while imem_req is high)
//   imem_ack    in   read data valid
//   imem_rdata  in   read data
//   ir          out  instruction register
//   opcode      out  ir[31:28]
//   mm          out  ir[27:24]
//   pc          out  program counter
//   fetch_done  out  one-cycle pulse: ir holds a new instruction
//   busy        out  high whenever the sequencer is not idle
//   fetch_err   out  sticky timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W    = 16,
    parameter int TMO_CYC = 15
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            fetch_req,
    input  logic            br_load,
    input  logic [PC_W-1:0] br_addr,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [PC_W-1:0] pc,
    output logic            fetch_done,
    output logic            busy,
    output logic            fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // Wide enough to hold the value TMO_CYC itself.
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_pend;
    logic [PC_W-1:0] r_pend_addr;
    logic            r_err;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_req;
    logic             w_ack;
    logic [PC_W-1:0]  w_pc_after_ack;
    logic [TMO_W-1:0] w_tmo_cnt_inc;
    logic             w_tmo_hit;

    assign w_req = (r_state == S_REQ) || (r_state == S_WAIT);

    // The memory response is only meaningful while a request is outstanding.
    assign w_ack = w_req && imem_ack;

    // A branch arriving in the same cycle as the ack wins over an older
    // pending target, which in turn wins over sequential advance.
    assign w_pc_after_ack = br_load ? br_addr :
                            r_pend  ? r_pend_addr :
                                      r_pc + PC_W'(1);

    assign w_tmo_cnt_inc = r_tmo_cnt + TMO_W'(1);

    // The counter would reach TMO_CYC at this edge: abandon the fetch.
    assign w_tmo_hit = TMO_EN && (r_state == S_WAIT) && !imem_ack &&
                       (w_tmo_cnt_inc == TMO_W'(TMO_CYC));

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (fetch_req) w_state_nxt = S_REQ;
            S_REQ:  w_state_nxt = imem_ack ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (imem_ack)       w_state_nxt = S_DONE;
                else if (w_tmo_hit) w_state_nxt = S_IDLE;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_err       <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Cleared in REQ so the first WAIT cycle starts from zero.
            if (r_state == S_REQ)
                r_tmo_cnt <= '0;
            else if (r_state == S_WAIT && !imem_ack)
                r_tmo_cnt <= w_tmo_cnt_inc;

            if (w_tmo_hit)
                r_err <= 1'b1;

            if (r_state == S_IDLE) begin
                // Direct redirect; also supersedes any stale pending target.
                if (br_load) begin
                    r_pc   <= br_addr;
                    r_pend <= 1'b0;
                end
            end else begin
                if (br_load) begin
                    r_pend      <= 1'b1;
                    r_pend_addr <= br_addr;
                end
                if (w_ack) begin
                    r_ir   <= imem_rdata;
                    r_pc   <= w_pc_after_ack;
                    r_pend <= 1'b0;
                end
            end
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign ir         = r_ir;
    assign opcode     = r_ir[31:28];
    assign mm         = r_ir[27:24];
    assign pc         = r_pc;
    assign fetch_done = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign fetch_err  = TMO_EN ? r_err : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A transaction-level model (fetch in
// flight / done flags, pc, ir, pending branch) predicts every output; a
// negedge compare process checks the DUT against it each cycle. Directed
// sequences pin the model with literal expectations, then a randomized phase
// drives requests, branches, acks and resets. Define FETCH_TIMEOUT_EN for
// both RTL and bench to exercise the timeout variant.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W    = 16;
    localparam int TMO_CYC = 15;

    logic            clk        = 1'b0;
    logic            rst_f      = 1'b0;
    logic            fetch_req  = 1'b0;
    logic            br_load    = 1'b0;
    logic [PC_W-1:0] br_addr    = '0;
    logic            imem_ack   = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     ir;
    logic [3:0]      opcode;
    logic [3:0]      mm;
    logic [PC_W-1:0] pc;
    logic            fetch_done;
    logic            busy;
    logic            fetch_err;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .TMO_CYC(TMO_CYC)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_req  (fetch_req),
        .br_load    (br_load),
        .br_addr    (br_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .pc         (pc),
        .fetch_done (fetch_done),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_valid = 1'b0;
    bit              m_act   = 1'b0;   // read outstanding
    bit              m_done  = 1'b0;   // completion pulse cycle
    bit              m_pend  = 1'b0;
    bit              m_err   = 1'b0;
    logic [PC_W-1:0] m_pc    = '0;
    logic [PC_W-1:0] m_paddr = '0;
    logic [31:0]     m_ir    = '0;
    int              m_req_cycles = 0;

    always @(posedge clk) begin
        if (!rst_f) begin
            m_valid = 1'b1;
            m_act = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_err = 1'b0;
            m_pc = '0; m_paddr = '0; m_ir = '0; m_req_cycles = 0;
        end else if (m_valid) begin
            if (m_done) begin
                m_done = 1'b0;
                if (br_load) begin m_pend = 1'b1; m_paddr = br_addr; end
            end else if (m_act) begin
                if (br_load) begin m_pend = 1'b1; m_paddr = br_addr; end
                if (imem_ack) begin
                    m_ir   = imem_rdata;
                    m_pc   = m_pend ? m_paddr : m_pc + PC_W'(1);
                    m_pend = 1'b0;
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_req_cycles++;
`ifdef FETCH_TIMEOUT_EN
                    // One REQ cycle plus TMO_CYC WAIT cycles without an ack.
                    if (m_req_cycles == TMO_CYC + 1) begin
                        m_act = 1'b0;
                        m_err = 1'b1;
                    end
`endif
                end
            end else begin
                if (br_load) begin m_pc = br_addr; m_pend = 1'b0; end
                if (fetch_req) begin m_act = 1'b1; m_req_cycles = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("imem_req",   {31'd0, imem_req},   {31'd0, m_act});
            check("busy",       {31'd0, busy},       {31'd0, m_act | m_done});
            check("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
            check("fetch_err",  {31'd0, fetch_err},  {31'd0, m_err});
            check("ir",         ir,                  m_ir);
            check("opcode",     {28'd0, opcode},     {28'd0, m_ir[31:28]});
            check("mm",         {28'd0, mm},         {28'd0, m_ir[27:24]});
            check("pc",         {16'd0, pc},         {16'd0, m_pc});
            if (m_act)
                check("imem_addr", {16'd0, imem_addr}, {16'd0, m_pc});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int req_cycles;

        // Reset state
        repeat (2) tick();
        check("rst ir", ir, 32'h0);
        check("rst pc", {16'd0, pc}, 32'h0);
        check("rst busy", {31'd0, busy}, 32'h0);
        check("rst imem_req", {31'd0, imem_req}, 32'h0);
        check("rst fetch_done", {31'd0, fetch_done}, 32'h0);
        check("rst fetch_err", {31'd0, fetch_err}, 32'h0);
        rst_f = 1'b1;

        // Minimum-latency fetch, ack in the first request cycle
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("min imem_req", {31'd0, imem_req}, 32'h1);
        check("min imem_addr", {16'd0, imem_addr}, 32'h0);
        check("min done early", {31'd0, fetch_done}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h8123_4567; tick(); imem_ack = 1'b0;
        check("min fetch_done", {31'd0, fetch_done}, 32'h1);
        check("min opcode", {28'd0, opcode}, 32'h8);
        check("min mm", {28'd0, mm}, 32'h1);
        check("min ir", ir, 32'h8123_4567);
        check("min pc", {16'd0, pc}, 32'h1);
        tick();
        check("min done cleared", {31'd0, fetch_done}, 32'h0);
        check("min idle", {31'd0, busy}, 32'h0);

        // Ack delayed by 5 cycles; a fetch_req mid-WAIT is ignored
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("slow imem_req held", {31'd0, imem_req}, 32'h1);
            check("slow imem_addr held", {16'd0, imem_addr}, 32'h1);
            check("slow no early done", {31'd0, fetch_done}, 32'h0);
            fetch_req  = (i == 2);
            imem_ack   = (i == 5);
            imem_rdata = 32'h1A2B_3C4D;
            tick();
        end
        imem_ack = 1'b0; fetch_req = 1'b0;
        check("slow fetch_done", {31'd0, fetch_done}, 32'h1);
        check("slow pc", {16'd0, pc}, 32'h2);
        tick();
        check("slow single pulse", {31'd0, fetch_done}, 32'h0);
        check("slow ignored req", {31'd0, busy}, 32'h0);

        // pc wraps from all-ones to zero
        br_load = 1'b1; br_addr = 16'hFFFF; tick(); br_load = 1'b0;
        check("wrap br pc", {16'd0, pc}, 32'hFFFF);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("wrap imem_addr", {16'd0, imem_addr}, 32'hFFFF);
        imem_ack = 1'b1; imem_rdata = 32'h0F00_0001; tick(); imem_ack = 1'b0;
        check("wrap pc", {16'd0, pc}, 32'h0);
        tick();

        // Branch while busy is held pending and replaces pc+1
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        tick();
        br_load = 1'b1; br_addr = 16'h0040; tick(); br_load = 1'b0;
        check("pend pc unchanged", {16'd0, pc}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h2200_0000; tick(); imem_ack = 1'b0;
        check("pend pc", {16'd0, pc}, 32'h40);
        tick();

        // Branch together with fetch_req in IDLE
        br_load = 1'b1; fetch_req = 1'b1; br_addr = 16'h0010; tick();
        br_load = 1'b0; fetch_req = 1'b0;
        check("brfetch imem_addr", {16'd0, imem_addr}, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'h3300_0000; tick(); imem_ack = 1'b0;
        check("brfetch pc", {16'd0, pc}, 32'h11);
        tick();

        // Reset during WAIT abandons the fetch
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        tick();
        rst_f = 1'b0; tick(); rst_f = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
        check("rstwait ir", ir, 32'h0);
        check("rstwait pc", {16'd0, pc}, 32'h0);
        check("rstwait done", {31'd0, fetch_done}, 32'h0);
        tick(); imem_ack = 1'b0;
        check("rstwait ir later", ir, 32'h0);
        check("rstwait done later", {31'd0, fetch_done}, 32'h0);
        check("rstwait idle", {31'd0, busy}, 32'h0);

        // Waiting without an ack
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        req_cycles = 0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 40 && imem_req; i++) begin
            req_cycles++;
            tick();
        end
        check("tmo req cycles", req_cycles, 32'd16);
        check("tmo fetch_err", {31'd0, fetch_err}, 32'h1);
        check("tmo pc", {16'd0, pc}, 32'h0);
        check("tmo no done", {31'd0, fetch_done}, 32'h0);
        check("tmo idle", {31'd0, busy}, 32'h0);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h4400_0000; tick(); imem_ack = 1'b0;
        check("tmo sticky", {31'd0, fetch_err}, 32'h1);
        tick();
        rst_f = 1'b0; tick(); rst_f = 1'b1;
        check("tmo err cleared", {31'd0, fetch_err}, 32'h0);
`else
        for (int i = 0; i < 30; i++) begin
            if (imem_req) req_cycles++;
            tick();
        end
        check("nolimit req cycles", req_cycles, 32'd30);
        check("nolimit fetch_err", {31'd0, fetch_err}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h4400_0000; tick(); imem_ack = 1'b0;
        check("nolimit done", {31'd0, fetch_done}, 32'h1);
        check("nolimit pc", {16'd0, pc}, 32'h1);
        tick();
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_f      = ($urandom_range(0, 149) != 0);
            fetch_req  = ($urandom_range(0, 2) == 0);
            br_load    = ($urandom_range(0, 7) == 0);
            br_addr    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            imem_ack   = ($urandom_range(0, 3) == 0);
            imem_rdata = $urandom;
            tick();
        end

        rst_f = 1'b1; fetch_req = 1'b0; br_load = 1'b0; imem_ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
